// File: rtl/pwm_fade_sequencer.sv
// Fade sequencer: steps each channel's duty toward its target once per tick
// and pushes every step to the PWM driver as a 16-bit SPI mode-0 write.
module pwm_fade_sequencer #(
    parameter int SCLK_DIV = 2,
    parameter int TICK_DIV = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tgt_valid,
    output logic       tgt_ready,
    input  logic [2:0] tgt_ch,
    input  logic [7:0] tgt_duty,
    output logic       sclk,
    output logic       cs,
    output logic       mosi,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, GAP} state_t;

    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = $clog2(2 * SCLK_DIV);
    localparam logic [TW-1:0] TICK_END = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(2 * SCLK_DIV - 1);

    state_t        state, state_n;
    logic [7:0]    tgt [0:6];
    logic [7:0]    cur [0:6];
    logic [TW-1:0] tick_cnt;
    logic          pending;
    logic [2:0]    idx;
    logic [15:0]   shreg;
    logic [3:0]    bit_cnt;
    logic [CW-1:0] cnt;

    logic       tick_wrap, start, differ, last, half_end;
    logic [7:0] cur_sel, tgt_sel, step;

    assign tick_wrap = (tick_cnt == TICK_END);
    assign start     = (state == IDLE) && pending;
    assign cur_sel   = cur[idx];
    assign tgt_sel   = tgt[idx];
    assign differ    = (cur_sel != tgt_sel);
    assign step      = (tgt_sel > cur_sel) ? cur_sel + 8'd1 : cur_sel - 8'd1;
    assign last      = (idx == 3'd6);
    assign half_end  = (cnt == HALF_END);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (pending) state_n = SCAN;
            SCAN: begin
                if (differ)    state_n = SHIFT;
                else if (last) state_n = IDLE;
            end
            SHIFT: if (half_end && sclk && bit_cnt == 4'd15) state_n = GAP;
            GAP:   if (cnt == GAP_END) state_n = last ? IDLE : SCAN;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        cs   = (state != SHIFT);
        mosi = (state == SHIFT) && shreg[15];
        busy = (state != IDLE);
    end

    // A tick arriving while a pass is already owed is dropped, not queued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tgt_ready <= 1'b0;
            tick_cnt  <= '0;
            pending   <= 1'b0;
            idx       <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            cnt       <= '0;
            sclk      <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                tgt[i] <= '0;
                cur[i] <= '0;
            end
        end else begin
            tgt_ready <= 1'b1;
            tick_cnt  <= tick_wrap ? '0 : tick_cnt + 1'b1;
            pending   <= (pending & ~start) | (tick_wrap & ~pending);
            if (tgt_valid && tgt_ready) begin
                for (int i = 0; i < 7; i++)
                    if (tgt_ch == 3'd7 || tgt_ch == 3'(i)) tgt[i] <= tgt_duty;
            end
            unique case (state)
                IDLE: begin
                    idx  <= '0;
                    cnt  <= '0;
                    sclk <= 1'b0;
                end
                SCAN: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    sclk    <= 1'b0;
                    if (differ) begin
                        cur[idx] <= step;
                        shreg    <= {1'b1, 4'b0000, idx, step};
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                SHIFT: begin
                    if (half_end) begin
                        cnt  <= '0;
                        sclk <= ~sclk;
                        if (sclk) begin
                            shreg   <= {shreg[14:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_END) begin
                        cnt <= '0;
                        idx <= idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Directed bench for pwm_fade_sequencer: decodes SPI frames off the pins
// and compares them with hand-computed expected write words.
module tb_pwm_fade_sequencer;
    localparam int SD = 2;
    localparam int TD = 64;

    logic       clk = 0;
    logic       reset = 0;
    logic       tgt_valid = 0;
    logic [2:0] tgt_ch = 0;
    logic [7:0] tgt_duty = 0;
    logic       tgt_ready, sclk, cs, mosi, busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pwm_fade_sequencer #(.SCLK_DIV(SD), .TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset),
        .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
        .tgt_ch(tgt_ch), .tgt_duty(tgt_duty),
        .sclk(sclk), .cs(cs), .mosi(mosi), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pin-level frame decoder
    logic [15:0] sh = 0;
    int lowc = 0, edges = 0, gapc = 0;
    logic pcs = 1, psclk = 0;
    logic [15:0] fq[$];
    int lq[$], eq[$], gq[$];

    always @(negedge clk) begin
        if (pcs && !cs) begin
            gq.push_back(gapc);
            lowc = 0;
            edges = 0;
        end
        if (!cs) begin
            lowc++;
            if (sclk && !psclk) begin
                sh = {sh[14:0], mosi};
                edges++;
            end
        end else begin
            if (!pcs) begin
                fq.push_back(sh);
                lq.push_back(lowc);
                eq.push_back(edges);
                gapc = 0;
            end
            gapc++;
        end
        pcs = cs;
        psclk = sclk;
    end

    task automatic clear_q();
        fq.delete(); lq.delete(); eq.delete(); gq.delete();
    endtask

    task automatic put(input logic [2:0] ch, input logic [7:0] d);
        @(negedge clk);
        tgt_valid = 1; tgt_ch = ch; tgt_duty = d;
        @(negedge clk);
        tgt_valid = 0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int k = 0;
        while (fq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, fq.size() >= n, 1);
    endtask

    task automatic wait_cs_low(input string tag);
        int k = 0;
        while (cs && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check(tag, cs, 0);
    endtask

    task automatic check_shape(input string tag, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (lq[i] != 32 * SD || eq[i] != 16) bad++;
        check(tag, bad, 0);
    endtask

    initial begin
        int viol, k, bad;
        logic [15:0] ramp[5];

        repeat (5) @(negedge clk);
        check("rst_ready", tgt_ready, 0);
        check("rst_cs", cs, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        reset = 1;
        @(negedge clk);
        check("ready_after_rst", tgt_ready, 1);
        viol = 0;
        repeat (2000) begin
            @(negedge clk);
            if (!cs || sclk || mosi) viol++;
        end
        check("idle_pins", viol, 0);
        check("idle_frames", fq.size(), 0);

        // Broadcast from all-zero state
        put(3'd7, 8'd1);
        wait_frames(7, 3000, "bc_wait");
        k = 0;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("bc_busy_fall", busy, 0);
        for (int i = 0; i < 7; i++)
            check($sformatf("bc_frame%0d", i), fq[i], 32'h8001 + (i << 8));
        check_shape("bc_shape", 7);
        bad = 0;
        for (int i = 1; i < 7; i++)
            if (gq[i] < 2 * SD || gq[i] > 2 * SD + 2) bad++;
        check("bc_gaps", bad, 0);
        repeat (400) @(negedge clk);
        check("bc_count", fq.size(), 7);
        clear_q();

        // Single ramp ch2 from 1 to 4
        put(3'd2, 8'd4);
        wait_frames(3, 2000, "ramp_wait");
        repeat (500) @(negedge clk);
        check("ramp_count", fq.size(), 3);
        check("ramp_f0", fq[0], 16'h8202);
        check("ramp_f1", fq[1], 16'h8203);
        check("ramp_f2", fq[2], 16'h8204);
        check_shape("ramp_shape", 3);
        clear_q();

        // Ramp down then retarget mid-frame
        put(3'd0, 8'd4);
        wait_frames(3, 2000, "up_wait");
        repeat (300) @(negedge clk);
        check("up_last", fq[2], 16'h8004);
        clear_q();
        put(3'd0, 8'd2);
        wait_frames(1, 2000, "dn_wait");
        wait_cs_low("dn_cs_fall");
        put(3'd0, 8'd5);
        wait_frames(5, 3000, "rt_wait");
        repeat (400) @(negedge clk);
        check("rt_count", fq.size(), 5);
        ramp = '{16'h8003, 16'h8002, 16'h8003, 16'h8004, 16'h8005};
        for (int i = 0; i < 5; i++)
            check($sformatf("rt_f%0d", i), fq[i], ramp[i]);
        clear_q();

        // Saturation ch6 from 1 up to 255
        put(3'd6, 8'd255);
        wait_frames(254, 40000, "sat_wait");
        repeat (400) @(negedge clk);
        check("sat_count", fq.size(), 254);
        bad = 0;
        for (int i = 0; i < fq.size(); i++)
            if (fq[i] != 16'h8602 + 16'(i)) bad++;
        check("sat_seq", bad, 0);
        check("sat_last", fq[253], 16'h86FF);
        check_shape("sat_shape", 254);
        bad = 0;
        for (int i = 1; i < gq.size(); i++)
            if (gq[i] < 2 * SD) bad++;
        check("sat_gaps", bad, 0);
        clear_q();

        // Reset in the middle of a frame
        put(3'd5, 8'd9);
        wait_cs_low("mr_cs_fall");
        k = 0;
        while (edges < 8 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("mr_bit8", edges >= 8, 1);
        #1 reset = 0;
        #1;
        check("mr_cs", cs, 1);
        check("mr_sclk", sclk, 0);
        check("mr_ready", tgt_ready, 0);
        repeat (3) @(negedge clk);
        reset = 1;
        clear_q();
        viol = 0;
        repeat (1500) begin
            @(negedge clk);
            if (!cs || sclk) viol++;
        end
        check("mr_quiet", viol, 0);
        check("mr_frames", fq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
